// File: rtl/axis_coproc_pkg.sv
// Shared types and sizing helpers for the AXI4-Stream matrix-vector coprocessor.
package axis_coproc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_COMPUTE,
        ST_WRITE
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned w;
        w = 0;
        while ((64'd1 << w) < 64'(v))
            w++;
        return w;
    endfunction

    // Index width for an n-entry buffer; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : clog2(n);
    endfunction

    function automatic int unsigned calc_nin(input int unsigned rows, input int unsigned cols);
        return rows * cols + cols;
    endfunction

    function automatic int unsigned calc_nout(input int unsigned rows);
        return rows;
    endfunction

endpackage

// File: rtl/matvec_mac.sv
// Single multiply-accumulate lane: registered operands, wrap-around accumulator.
module matvec_mac #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OP_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  clr,
    input  logic                  last,
    input  logic [OP_WIDTH-1:0]   a,
    input  logic [OP_WIDTH-1:0]   b,
    output logic [DATA_WIDTH-1:0] acc,
    output logic                  wr
);

    localparam int unsigned PW = (2 * OP_WIDTH > DATA_WIDTH) ? 2 * OP_WIDTH : DATA_WIDTH;

    logic [OP_WIDTH-1:0]   a_q, b_q;
    logic                  clr_q, last_q, vld_q;
    logic [DATA_WIDTH-1:0] acc_q;
    logic [PW-1:0]         prod_w;

    assign prod_w = PW'(a_q) * PW'(b_q);
    // acc is the running sum including the product currently held in the operand registers.
    assign acc    = (clr_q ? '0 : acc_q) + prod_w[DATA_WIDTH-1:0];
    assign wr     = vld_q && last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            clr_q  <= 1'b0;
            last_q <= 1'b0;
            vld_q  <= 1'b0;
            acc_q  <= '0;
        end else begin
            vld_q <= en;
            if (en) begin
                a_q    <= a;
                b_q    <= b;
                clr_q  <= clr;
                last_q <= last;
            end
            if (vld_q)
                acc_q <= acc;
        end
    end

endmodule

// File: rtl/axis_matvec_coproc.sv
// AXI4-Stream matrix-vector coprocessor: reads A then B, computes R = A*B with one MAC, streams R.
module axis_matvec_coproc
    import axis_coproc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OP_WIDTH   = 16,
    parameter int unsigned ROWS       = 2,
    parameter int unsigned COLS       = 2
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    output logic                  S_AXIS_TREADY,
    input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic                  S_AXIS_TLAST,
    input  logic                  S_AXIS_TVALID,
    output logic                  M_AXIS_TVALID,
    output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                  M_AXIS_TLAST,
    input  logic                  M_AXIS_TREADY,
    output logic                  ERR
);

    localparam int unsigned RC   = ROWS * COLS;
    localparam int unsigned NIN  = calc_nin(ROWS, COLS);
    localparam int unsigned NOUT = calc_nout(ROWS);
    localparam int unsigned CW   = clog2(NIN + 1);
    localparam int unsigned AW   = idx_width(RC);
    localparam int unsigned BW   = idx_width(COLS);
    localparam int unsigned RW   = idx_width(NOUT);

    state_t                state;
    logic [CW-1:0]         wcnt, cnt, col, wrow, kout, knext, bidx;
    logic                  accept, store;
    logic                  mac_en, mac_clr, mac_last, mac_wr;
    logic [OP_WIDTH-1:0]   op_a, op_b;
    logic [DATA_WIDTH-1:0] acc;

    logic [OP_WIDTH-1:0]   a_buf [RC];
    logic [OP_WIDTH-1:0]   b_buf [COLS];
    logic [DATA_WIDTH-1:0] r_buf [NOUT];

    generate
        if (DATA_WIDTH > OP_WIDTH) begin : g_hi_bits
            logic unused_hi;
            assign unused_hi = ^S_AXIS_TDATA[DATA_WIDTH-1:OP_WIDTH];
        end
    endgenerate

    assign accept   = S_AXIS_TVALID && S_AXIS_TREADY;
    assign store    = accept && (state == ST_IDLE || state == ST_READ);
    assign bidx     = wcnt - CW'(RC);
    assign knext    = kout + CW'(1);
    // cnt runs one step past RC so the last product can settle before WRITE.
    assign mac_en   = (state == ST_COMPUTE) && (cnt != CW'(RC));
    assign mac_clr  = (col == '0);
    assign mac_last = (col == CW'(COLS - 1));

    always_comb begin
        op_a = '0;
        op_b = '0;
        if (mac_en) begin
            op_a = a_buf[cnt[AW-1:0]];
            op_b = b_buf[col[BW-1:0]];
        end
    end

    matvec_mac #(
        .DATA_WIDTH(DATA_WIDTH),
        .OP_WIDTH  (OP_WIDTH)
    ) u_mac (
        .clk  (ACLK),
        .rst_n(ARESETN),
        .en   (mac_en),
        .clr  (mac_clr),
        .last (mac_last),
        .a    (op_a),
        .b    (op_b),
        .acc  (acc),
        .wr   (mac_wr)
    );

    always_ff @(posedge ACLK) begin
        if (store) begin
            if (wcnt < CW'(RC))
                a_buf[wcnt[AW-1:0]] <= S_AXIS_TDATA[OP_WIDTH-1:0];
            else
                b_buf[bidx[BW-1:0]] <= S_AXIS_TDATA[OP_WIDTH-1:0];
        end
        if (mac_wr)
            r_buf[wrow[RW-1:0]] <= acc;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state         <= ST_IDLE;
            S_AXIS_TREADY <= 1'b0;
            M_AXIS_TVALID <= 1'b0;
            M_AXIS_TDATA  <= '0;
            M_AXIS_TLAST  <= 1'b0;
            ERR           <= 1'b0;
            wcnt          <= '0;
            cnt           <= '0;
            col           <= '0;
            wrow          <= '0;
            kout          <= '0;
        end else begin
            if (mac_wr)
                wrow <= wrow + CW'(1);
            unique case (state)
                ST_IDLE, ST_READ: begin
                    S_AXIS_TREADY <= 1'b1;
                    if (accept) begin
                        if (state == ST_IDLE)
                            ERR <= 1'b0;
                        if (wcnt == CW'(NIN - 1)) begin
                            wcnt <= '0;
                            if (S_AXIS_TLAST) begin
                                state         <= ST_COMPUTE;
                                S_AXIS_TREADY <= 1'b0;
                                cnt           <= '0;
                                col           <= '0;
                                wrow          <= '0;
                            end else begin
                                ERR   <= 1'b1;
                                state <= ST_DRAIN;
                            end
                        end else if (S_AXIS_TLAST) begin
                            ERR   <= 1'b1;
                            wcnt  <= '0;
                            state <= ST_IDLE;
                        end else begin
                            wcnt  <= wcnt + CW'(1);
                            state <= ST_READ;
                        end
                    end
                end
                ST_DRAIN: begin
                    S_AXIS_TREADY <= 1'b1;
                    if (accept && S_AXIS_TLAST)
                        state <= ST_IDLE;
                end
                ST_COMPUTE: begin
                    if (cnt == CW'(RC)) begin
                        state         <= ST_WRITE;
                        M_AXIS_TVALID <= 1'b1;
                        // With a single row the result lands in r_buf on this same edge.
                        M_AXIS_TDATA  <= (NOUT == 1) ? acc : r_buf[0];
                        M_AXIS_TLAST  <= (NOUT == 1);
                        kout          <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                        col <= (col == CW'(COLS - 1)) ? '0 : col + CW'(1);
                    end
                end
                ST_WRITE: begin
                    if (M_AXIS_TREADY) begin
                        if (M_AXIS_TLAST) begin
                            M_AXIS_TVALID <= 1'b0;
                            M_AXIS_TLAST  <= 1'b0;
                            S_AXIS_TREADY <= 1'b1;
                            state         <= ST_IDLE;
                        end else begin
                            kout         <= knext;
                            M_AXIS_TDATA <= r_buf[knext[RW-1:0]];
                            M_AXIS_TLAST <= (knext == CW'(NOUT - 1));
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_matvec_coproc.sv
// Randomised self-checking bench for axis_matvec_coproc against a plain-arithmetic reference model.
module tb_axis_matvec_coproc;

    localparam int DW   = 32;
    localparam int OW   = 16;
    localparam int ROWS = 2;
    localparam int COLS = 2;
    localparam int RC   = ROWS * COLS;
    localparam int NIN  = RC + COLS;

    logic          ACLK = 1'b0;
    logic          ARESETN = 1'b1;
    logic          S_AXIS_TREADY;
    logic [DW-1:0] S_AXIS_TDATA = '0;
    logic          S_AXIS_TLAST = 1'b0;
    logic          S_AXIS_TVALID = 1'b0;
    logic          M_AXIS_TVALID;
    logic [DW-1:0] M_AXIS_TDATA;
    logic          M_AXIS_TLAST;
    logic          M_AXIS_TREADY = 1'b1;
    logic          ERR;

    axis_matvec_coproc #(
        .DATA_WIDTH(DW),
        .OP_WIDTH  (OW),
        .ROWS      (ROWS),
        .COLS      (COLS)
    ) dut (
        .ACLK         (ACLK),
        .ARESETN      (ARESETN),
        .S_AXIS_TREADY(S_AXIS_TREADY),
        .S_AXIS_TDATA (S_AXIS_TDATA),
        .S_AXIS_TLAST (S_AXIS_TLAST),
        .S_AXIS_TVALID(S_AXIS_TVALID),
        .M_AXIS_TVALID(M_AXIS_TVALID),
        .M_AXIS_TDATA (M_AXIS_TDATA),
        .M_AXIS_TLAST (M_AXIS_TLAST),
        .M_AXIS_TREADY(M_AXIS_TREADY),
        .ERR          (ERR)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_in_cyc = 0;
    int rdy_mode = 0;
    int stalls = 0;
    bit gap_en = 1'b0;

    logic [DW-1:0] fw [NIN];
    logic [DW-1:0] exp_q[$];
    logic          exp_last_q[$];
    logic [DW-1:0] got_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Reference: R[r] = sum_c A[r][c]*B[c] over the low OW bits, reduced mod 2^DW.
    task automatic model_frame();
        logic [63:0] s;
        for (int r = 0; r < ROWS; r++) begin
            s = '0;
            for (int c = 0; c < COLS; c++)
                s += 64'(fw[r*COLS+c][OW-1:0]) * 64'(fw[RC+c][OW-1:0]);
            exp_q.push_back(s[DW-1:0]);
            exp_last_q.push_back(r == ROWS - 1);
        end
    endtask

    always @(posedge ACLK) cyc <= cyc + 1;

    always @(posedge ACLK) begin
        #1;
        case (rdy_mode)
            0: M_AXIS_TREADY = 1'b1;
            1: M_AXIS_TREADY = 1'($urandom_range(0, 1));
            2: begin
                if (M_AXIS_TVALID && stalls < 3) begin
                    M_AXIS_TREADY = 1'b0;
                    stalls++;
                end else begin
                    M_AXIS_TREADY = 1'b1;
                end
            end
            default: M_AXIS_TREADY = 1'b0;
        endcase
    end

    logic          prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0;
    logic [DW-1:0] prev_d = '0;

    always @(negedge ACLK) begin
        if (!ARESETN) begin
            prev_v = 1'b0;
        end else begin
            if (M_AXIS_TVALID && !prev_v)
                check("latency", 64'(cyc - last_in_cyc), 64'(RC + 1));
            if (prev_v && !prev_r) begin
                check("hold_tvalid", M_AXIS_TVALID, 1);
                check("hold_tdata", M_AXIS_TDATA, prev_d);
                check("hold_tlast", M_AXIS_TLAST, prev_l);
            end
            if (M_AXIS_TVALID)
                check("s_tready_during_out", S_AXIS_TREADY, 0);
            if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                got_q.push_back(M_AXIS_TDATA);
                if (exp_q.size() == 0) begin
                    check("unexpected_output", M_AXIS_TVALID, 0);
                end else begin
                    check("tdata", M_AXIS_TDATA, exp_q.pop_front());
                    check("tlast", M_AXIS_TLAST, exp_last_q.pop_front());
                end
            end
            prev_v = M_AXIS_TVALID;
            prev_r = M_AXIS_TREADY;
            prev_d = M_AXIS_TDATA;
            prev_l = M_AXIS_TLAST;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    task automatic send_word(input logic [DW-1:0] d, input logic l);
        int t;
        t = 0;
        S_AXIS_TDATA  = d;
        S_AXIS_TLAST  = l;
        S_AXIS_TVALID = 1'b1;
        @(negedge ACLK);
        while (!S_AXIS_TREADY && t < 300) begin
            @(negedge ACLK);
            t++;
        end
        if (!S_AXIS_TREADY)
            check("s_tready_timeout", S_AXIS_TREADY, 1);
        @(posedge ACLK);
        #1;
        last_in_cyc   = cyc;
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST  = 1'b0;
    endtask

    task automatic send_seq(input int n, input int last_at);
        for (int i = 0; i < n; i++) begin
            send_word((i < NIN) ? fw[i] : $urandom(), i == last_at);
            if (gap_en && $urandom_range(0, 3) == 0)
                cycles(1);
        end
    endtask

    task automatic wait_out();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || M_AXIS_TVALID) && t < 2000) begin
            cycles(1);
            t++;
        end
        check("out_drain_timeout", 64'(exp_q.size()), 0);
    endtask

    task automatic do_reset();
        @(negedge ACLK);
        #2;
        ARESETN = 1'b0;
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST  = 1'b0;
        #1;
        check("rst_m_tvalid", M_AXIS_TVALID, 0);
        check("rst_m_tdata", M_AXIS_TDATA, 0);
        check("rst_m_tlast", M_AXIS_TLAST, 0);
        check("rst_s_tready", S_AXIS_TREADY, 0);
        check("rst_err", ERR, 0);
        exp_q.delete();
        exp_last_q.delete();
        repeat (2) @(negedge ACLK);
        #2;
        ARESETN = 1'b1;
        cycles(1);
    endtask

    task automatic rand_frame();
        for (int i = 0; i < NIN; i++)
            fw[i] = $urandom();
    endtask

    task automatic check_pair(input string name, input logic [DW-1:0] e0, input logic [DW-1:0] e1);
        check({name, "_count"}, 64'(got_q.size()), 2);
        if (got_q.size() == 2) begin
            check({name, "_r0"}, got_q[0], e0);
            check({name, "_r1"}, got_q[1], e1);
        end
    endtask

    initial begin
        do_reset();

        // Hand-computed frame: A=[[1,2],[3,4]], B=[5,6] -> 17, 39.
        for (int i = 0; i < NIN; i++)
            fw[i] = DW'(i + 1);
        got_q.delete();
        model_frame();
        send_seq(NIN, NIN - 1);
        wait_out();
        check_pair("t1", 32'd17, 32'd39);
        check("t1_err", ERR, 0);

        // Downstream stall for three cycles on the first result.
        rdy_mode = 2;
        stalls = 0;
        got_q.delete();
        model_frame();
        send_seq(NIN, NIN - 1);
        wait_out();
        check_pair("t2", 32'd17, 32'd39);
        rdy_mode = 0;

        // Early TLAST on word 3, then a good frame clears ERR on its first word.
        got_q.delete();
        send_seq(3, 2);
        check("t3_err_set", ERR, 1);
        cycles(20);
        check("t3_no_out", 64'(got_q.size()), 0);
        rand_frame();
        model_frame();
        send_word(fw[0], 1'b0);
        check("t3_err_cleared", ERR, 0);
        for (int i = 1; i < NIN; i++)
            send_word(fw[i], i == NIN - 1);
        wait_out();
        check("t3_good_count", 64'(got_q.size()), 2);

        // Missing TLAST: extras are drained, no output.
        got_q.delete();
        send_seq(NIN, -1);
        check("t4_err_set", ERR, 1);
        check("t4_draining_ready", S_AXIS_TREADY, 1);
        send_word($urandom(), 1'b0);
        send_word($urandom(), 1'b1);
        cycles(1);
        check("t4_idle_ready", S_AXIS_TREADY, 1);
        cycles(20);
        check("t4_no_out", 64'(got_q.size()), 0);
        check("t4_err_sticky", ERR, 1);

        // Operand saturation with junk in the upper bits.
        for (int i = 0; i < NIN; i++)
            fw[i] = 32'hABCD_FFFF;
        got_q.delete();
        model_frame();
        send_seq(NIN, NIN - 1);
        wait_out();
        check_pair("t5", 32'hFFFC_0002, 32'hFFFC_0002);
        check("t5_err", ERR, 0);

        // Reset during COMPUTE.
        rand_frame();
        model_frame();
        got_q.delete();
        send_seq(NIN, NIN - 1);
        cycles(2);
        do_reset();
        cycles(20);
        check("t6a_no_out", 64'(got_q.size()), 0);
        rand_frame();
        model_frame();
        send_seq(NIN, NIN - 1);
        wait_out();
        check("t6a_after_count", 64'(got_q.size()), 2);

        // Reset during WRITE while downstream is blocked.
        rdy_mode = 3;
        rand_frame();
        model_frame();
        send_seq(NIN, NIN - 1);
        for (int t = 0; t < 100 && !M_AXIS_TVALID; t++)
            cycles(1);
        check("t6b_tvalid_up", M_AXIS_TVALID, 1);
        do_reset();
        rdy_mode = 0;
        got_q.delete();
        rand_frame();
        model_frame();
        send_seq(NIN, NIN - 1);
        wait_out();
        check("t6b_after_count", 64'(got_q.size()), 2);

        // Random traffic with random backpressure and occasional short frames.
        rdy_mode = 1;
        gap_en = 1'b1;
        for (int f = 0; f < 30; f++) begin
            rand_frame();
            if ($urandom_range(0, 4) == 0) begin
                int k;
                k = $urandom_range(1, NIN - 1);
                send_seq(k, k - 1);
                check("rnd_err_set", ERR, 1);
            end else begin
                model_frame();
                send_seq(NIN, NIN - 1);
            end
        end
        wait_out();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1);
    end

endmodule
